// File: rtl/mmio_uart_ctrl_if.sv
// mmio_uart_ctrl_if: MEM-stage I/O bus plus UART TX/RX byte handshakes
//   master: CPU/UART side (drives address, store data, requests, UART inputs)
//   slave : controller side (drives load data, stall, UART TX byte, RX ready)
interface mmio_uart_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retire;
    logic [31:0] io_rdata;
    logic        stall;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;
    modport master (
        output addr, wdata, we, re, inst_retire, uart_din_ready, uart_dout, uart_dout_valid,
        input  io_rdata, stall, uart_din, uart_din_valid, uart_dout_ready
    );
    modport slave (
        input  addr, wdata, we, re, inst_retire, uart_din_ready, uart_dout, uart_dout_valid,
        output io_rdata, stall, uart_din, uart_din_valid, uart_dout_ready
    );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MEM-stage memory-mapped UART controller with cycle/instruction counters
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : MEM-stage load/store, retire strobe, load data, stall, UART TX/RX handshakes
module mmio_uart_ctrl #(
    parameter logic [3:0] IO_NIBBLE = 4'h8,
    parameter int          CNT_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mmio_uart_ctrl_if.slave bus
);
    typedef enum logic {T_EMPTY, T_FULL} tx_state_t;
    typedef enum logic {R_EMPTY, R_FULL} rx_state_t;
    tx_state_t              r_tx_state, w_tx_next;
    rx_state_t              r_rx_state, w_rx_next;
    logic [7:0]             r_tx_byte, r_rx_byte;
    logic [CNT_WIDTH-1:0]   r_cycle_cnt, r_instr_cnt;
    logic [31:0]            r_rdata, w_rdata;
    logic                   w_io_sel, w_tx_wr, w_clr, w_stall, w_load, w_rx_rd;
    logic                   w_unused;
    always_comb begin
        w_io_sel  = bus.addr[31:28] == IO_NIBBLE;
        w_tx_wr   = w_io_sel && bus.we && bus.addr[5:2] == 4'h2;
        w_clr     = w_io_sel && bus.we && bus.addr[5:2] == 4'h6;
        // stall depends only on registered TX state, never on uart_din_ready
        w_stall   = w_tx_wr && r_tx_state == T_FULL;
        // a store wins over a simultaneous load, so the load neither pops RX nor updates data
        w_load    = w_io_sel && bus.re && !bus.we && !w_stall;
        w_rx_rd   = w_load && bus.addr[5:2] == 4'h3;
        w_tx_next = r_tx_state == T_EMPTY ? (w_tx_wr ? T_FULL : T_EMPTY)
                                          : (bus.uart_din_ready ? T_EMPTY : T_FULL);
        w_rx_next = r_rx_state == R_EMPTY ? (bus.uart_dout_valid ? R_FULL : R_EMPTY)
                                          : (w_rx_rd ? R_EMPTY : R_FULL);
        w_rdata   = bus.addr[5:2] == 4'h0 ? {31'b0, r_tx_state == T_EMPTY} :
                    bus.addr[5:2] == 4'h1 ? {31'b0, r_rx_state == R_FULL}  :
                    bus.addr[5:2] == 4'h3 ? {24'b0, r_rx_byte}             :
                    bus.addr[5:2] == 4'h4 ? 32'(r_cycle_cnt)               :
                    bus.addr[5:2] == 4'h5 ? 32'(r_instr_cnt)               : 32'b0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state  <= T_EMPTY;
            r_rx_state  <= R_EMPTY;
            r_tx_byte   <= '0;
            r_rx_byte   <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_rdata     <= '0;
        end else begin
            r_tx_state  <= w_tx_next;
            r_rx_state  <= w_rx_next;
            if (r_tx_state == T_EMPTY && w_tx_wr) r_tx_byte <= bus.wdata[7:0];
            if (r_rx_state == R_EMPTY && bus.uart_dout_valid) r_rx_byte <= bus.uart_dout;
            r_cycle_cnt <= w_clr ? '0 : r_cycle_cnt + CNT_WIDTH'(1);
            r_instr_cnt <= w_clr ? '0 : r_instr_cnt + CNT_WIDTH'(bus.inst_retire);
            if (w_load) r_rdata <= w_rdata;
        end
    end
    assign bus.io_rdata        = r_rdata;
    assign bus.stall           = w_stall;
    assign bus.uart_din        = r_tx_byte;
    assign bus.uart_din_valid  = r_tx_state == T_FULL;
    assign bus.uart_dout_ready = r_rx_state == R_EMPTY;
    assign w_unused            = ^{bus.addr[27:6], bus.addr[1:0], bus.wdata[31:8]};
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed-vector bench for mmio_uart_ctrl
module tb_mmio_uart_ctrl;
    logic        clk;
    logic        rst;
    int          n_vec;
    int          n_err;
    int          n_hs;
    logic [7:0]  hs_byte;
    mmio_uart_ctrl_if bus ();
    mmio_uart_ctrl #(.IO_NIBBLE(4'h8), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rst && bus.uart_din_valid && bus.uart_din_ready) begin
            n_hs    <= n_hs + 1;
            hs_byte <= bus.uart_din;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        bus.we    = w;
        bus.re    = r;
        bus.addr  = a;
        bus.wdata = d;
        #1;
    endtask
    initial begin
        n_vec = 0;
        n_err = 0;
        n_hs  = 0;
        hs_byte = '0;
        rst = 1'b0;
        bus.inst_retire     = 1'b0;
        bus.uart_din_ready  = 1'b0;
        bus.uart_dout       = 8'h00;
        bus.uart_dout_valid = 1'b0;
        op(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_din_valid", 32'(bus.uart_din_valid), 32'd0);
        chk("rst_dout_ready", 32'(bus.uart_dout_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_rdata", bus.io_rdata, 32'h0);
        op(1'b0, 1'b1, 32'h8000_0010, 32'h0);
        cyc();
        chk("first_cycle_cnt", bus.io_rdata, 32'h0);
        op(1'b1, 1'b0, 32'h8000_0008, 32'h0000_0041);
        chk("tx1_nostall", 32'(bus.stall), 32'd0);
        cyc();
        op(1'b0, 1'b0, 32'h0, 32'h0);
        chk("tx1_valid", 32'(bus.uart_din_valid), 32'd1);
        chk("tx1_byte", 32'(bus.uart_din), 32'h41);
        op(1'b1, 1'b0, 32'h8000_0008, 32'h0000_0042);
        chk("tx2_stall_a", 32'(bus.stall), 32'd1);
        cyc();
        chk("tx2_stall_b", 32'(bus.stall), 32'd1);
        bus.uart_din_ready = 1'b1;
        #1;
        chk("tx2_stall_hs", 32'(bus.stall), 32'd1);
        cyc();
        bus.uart_din_ready = 1'b0;
        #1;
        chk("tx2_stall_drop", 32'(bus.stall), 32'd0);
        chk("tx2_empty_valid", 32'(bus.uart_din_valid), 32'd0);
        cyc();
        op(1'b0, 1'b0, 32'h0, 32'h0);
        chk("tx2_valid", 32'(bus.uart_din_valid), 32'd1);
        chk("tx2_byte", 32'(bus.uart_din), 32'h42);
        chk("tx1_hs_count", 32'(n_hs), 32'd1);
        chk("tx1_hs_byte", 32'(hs_byte), 32'h41);
        bus.uart_din_ready = 1'b1;
        cyc();
        bus.uart_din_ready = 1'b0;
        chk("tx2_hs_byte", 32'(hs_byte), 32'h42);
        chk("tx_drained", 32'(bus.uart_din_valid), 32'd0);
        op(1'b0, 1'b1, 32'h8000_0000, 32'h0);
        cyc();
        chk("tx_ready_rd", bus.io_rdata, 32'h1);
        op(1'b0, 1'b0, 32'h0, 32'h0);
        bus.uart_dout = 8'h5A;
        bus.uart_dout_valid = 1'b1;
        cyc();
        bus.uart_dout_valid = 1'b0;
        bus.uart_dout = 8'hC3;
        chk("rx_ready_low", 32'(bus.uart_dout_ready), 32'd0);
        op(1'b0, 1'b1, 32'h8000_0004, 32'h0);
        cyc();
        chk("rx_full_rd", bus.io_rdata, 32'h1);
        op(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        cyc();
        chk("rx_byte_rd", bus.io_rdata, 32'h5A);
        chk("rx_ready_high", 32'(bus.uart_dout_ready), 32'd1);
        op(1'b0, 1'b1, 32'h8000_0004, 32'h0);
        cyc();
        chk("rx_empty_rd", bus.io_rdata, 32'h0);
        op(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        cyc();
        chk("rx_stale_rd", bus.io_rdata, 32'h5A);
        chk("rx_stale_ready", 32'(bus.uart_dout_ready), 32'd1);
        op(1'b1, 1'b0, 32'h8000_0018, 32'h0);
        cyc();
        op(1'b0, 1'b1, 32'h8000_0010, 32'h0);
        cyc();
        chk("clr_cycle", bus.io_rdata, 32'h0);
        op(1'b0, 1'b1, 32'h8000_0014, 32'h0);
        cyc();
        chk("clr_instr", bus.io_rdata, 32'h0);
        op(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            bus.inst_retire = (i % 3 == 0);
            cyc();
        end
        bus.inst_retire = 1'b0;
        op(1'b0, 1'b1, 32'h8000_0014, 32'h0);
        cyc();
        chk("instr_cnt4", bus.io_rdata, 32'd4);
        op(1'b0, 1'b1, 32'h8000_0010, 32'h0);
        cyc();
        chk("cycle_cnt13", bus.io_rdata, 32'd13);
        bus.inst_retire = 1'b1;
        op(1'b1, 1'b0, 32'h8000_0018, 32'h0);
        cyc();
        bus.inst_retire = 1'b0;
        op(1'b0, 1'b1, 32'h8000_0014, 32'h0);
        cyc();
        chk("clr_prio_instr", bus.io_rdata, 32'h0);
        force dut.r_cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle_cnt;
        op(1'b0, 1'b1, 32'h8000_0010, 32'h0);
        cyc();
        chk("wrap_pre", bus.io_rdata, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_post", bus.io_rdata, 32'h0);
        op(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        cyc();
        op(1'b0, 1'b1, 32'h8000_0020, 32'h0);
        cyc();
        chk("unmapped_rd", bus.io_rdata, 32'h0);
        op(1'b1, 1'b0, 32'h8000_0024, 32'hFFFF_FFFF);
        chk("unmapped_wr_stall", 32'(bus.stall), 32'd0);
        cyc();
        chk("unmapped_wr_tx", 32'(bus.uart_din_valid), 32'd0);
        op(1'b1, 1'b0, 32'h1000_0008, 32'h0000_0077);
        cyc();
        chk("nonio_wr_tx", 32'(bus.uart_din_valid), 32'd0);
        op(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        cyc();
        op(1'b0, 1'b1, 32'h1000_0000, 32'h0);
        cyc();
        chk("nonio_rd_hold", bus.io_rdata, 32'h5A);
        op(1'b1, 1'b0, 32'h8000_0008, 32'h0000_0099);
        bus.uart_dout = 8'h66;
        bus.uart_dout_valid = 1'b1;
        cyc();
        op(1'b0, 1'b0, 32'h0, 32'h0);
        bus.uart_dout_valid = 1'b0;
        chk("mid_tx_valid", 32'(bus.uart_din_valid), 32'd1);
        chk("mid_rx_ready", 32'(bus.uart_dout_ready), 32'd0);
        rst = 1'b0;
        bus.uart_din_ready = 1'b1;
        cyc();
        rst = 1'b1;
        bus.uart_din_ready = 1'b0;
        chk("mid_rst_tx", 32'(bus.uart_din_valid), 32'd0);
        chk("mid_rst_rx", 32'(bus.uart_dout_ready), 32'd1);
        chk("mid_rst_hs", 32'(hs_byte), 32'h42);
        op(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        cyc();
        chk("mid_rst_rxbyte", bus.io_rdata, 32'h0);
        op(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
